// File: rtl/lbr_pkg.sv
// Shared types and helpers for the last-branch-record ring buffer.
// Holds the stored entry layout, index/count width derivation and the compaction counters.
package lbr_pkg;

    localparam int LBR_DATA_W = 32;
    localparam int MAX_CH     = 16;

    typedef logic [MAX_CH-1:0] ch_mask_t;

    typedef struct packed {
        logic [LBR_DATA_W-1:0] from_addr;
        logic [LBR_DATA_W-1:0] to_addr;
        logic                  mispred;
    } lbr_entry_t;

    function automatic int idx_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic int cnt_w(input int size);
        return idx_w(size) + 1;
    endfunction

    // Number of set bits strictly below position n.
    function automatic int prefix_count(input ch_mask_t m, input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < n && m[i]) acc++;
        end
        return acc;
    endfunction

    function automatic int popcount(input ch_mask_t m);
        return prefix_count(m, MAX_CH);
    endfunction

endpackage

// File: rtl/lbr_ring_buffer_if.sv
// Commit-side push, CSR read path and status bundle for the LBR ring buffer.
// The commit/debug side drives through master; the buffer sits on slave.
interface lbr_ring_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LBR_SIZE   = 16,
    parameter int NUM_CH     = 2,
    parameter int IDX_W      = lbr_pkg::idx_w(LBR_SIZE)
);
    logic                         enable;
    logic                         freeze_on_full;
    logic                         clear;
    logic [NUM_CH-1:0]            rec_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] rec_from;
    logic [NUM_CH*DATA_WIDTH-1:0] rec_to;
    logic [NUM_CH-1:0]            rec_mispred;
    logic                         rd_req;
    logic [IDX_W-1:0]             rd_idx;
    logic                         rd_ack;
    logic                         rd_hit;
    logic [DATA_WIDTH-1:0]        rd_from;
    logic [DATA_WIDTH-1:0]        rd_to;
    logic                         rd_mispred;
    logic [IDX_W-1:0]             tos;
    logic [IDX_W:0]               count;
    logic                         overflow;
    logic                         frozen;

    modport master (
        output enable, freeze_on_full, clear, rec_valid, rec_from, rec_to, rec_mispred,
               rd_req, rd_idx,
        input  rd_ack, rd_hit, rd_from, rd_to, rd_mispred, tos, count, overflow, frozen
    );

    modport slave (
        input  enable, freeze_on_full, clear, rec_valid, rec_from, rec_to, rec_mispred,
               rd_req, rd_idx,
        output rd_ack, rd_hit, rd_from, rd_to, rd_mispred, tos, count, overflow, frozen
    );
endinterface

// File: rtl/lbr_push_compact.sv
// Combinational push compaction: per-channel slot offset among valid channels, plus total valid count.
// Zero latency; no backpressure (the caller decides how many slots are actually taken).
module lbr_push_compact
    import lbr_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic [NUM_CH-1:0]            rec_valid,
    output logic [NUM_CH-1:0][IDX_W-1:0] wr_off,
    output logic [CNT_W-1:0]             v_cnt
);

    ch_mask_t mask;

    always_comb begin
        mask              = '0;
        mask[NUM_CH-1:0]  = rec_valid;
        v_cnt             = CNT_W'(popcount(mask));
        for (int c = 0; c < NUM_CH; c++) begin
            wr_off[c] = IDX_W'(prefix_count(mask, c));
        end
    end

endmodule

// File: rtl/lbr_ring_buffer.sv
// Last-branch-record circular store: packs up to NUM_CH retiring branches per cycle, tracks TOS/count/overflow/freeze.
// Reads return one cycle after rd_req from pre-edge state; pushes are never stalled, only dropped when gated or frozen.
module lbr_ring_buffer
    import lbr_pkg::*;
#(
    parameter int DATA_WIDTH = LBR_DATA_W,
    parameter int LBR_SIZE   = 16,
    parameter int NUM_CH     = 2,
    localparam int IDX_W     = idx_w(LBR_SIZE),
    localparam int CNT_W     = cnt_w(LBR_SIZE)
) (
    input  logic              clock,
    input  logic              reset,
    lbr_ring_buffer_if.slave  bus
);

    // One extra bit so count + pushes never wraps, even when NUM_CH == LBR_SIZE.
    localparam int SUM_W = CNT_W + 1;

    logic [IDX_W-1:0]      tos_q, tos_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  frozen_q, frozen_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_hit_q, rd_hit_d;
    logic [DATA_WIDTH-1:0] rd_from_q, rd_from_d;
    logic [DATA_WIDTH-1:0] rd_to_q, rd_to_d;
    logic                  rd_mispred_q, rd_mispred_d;

    lbr_entry_t mem_q [LBR_SIZE];
    lbr_entry_t mem_d [LBR_SIZE];

    logic [NUM_CH-1:0][IDX_W-1:0] wr_off;
    logic [NUM_CH-1:0][IDX_W-1:0] wr_addr;
    logic [NUM_CH-1:0]            wr_en;
    logic [CNT_W-1:0]             v_cnt;

    logic                  push_ok;
    logic [SUM_W-1:0]      v_sum, room, keep, live_sum;
    logic [IDX_W-1:0]      rd_phys;
    logic                  rd_hit_now;

    lbr_push_compact #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W)
    ) u_compact (
        .rec_valid (bus.rec_valid),
        .wr_off    (wr_off),
        .v_cnt     (v_cnt)
    );

    // Number of records actually stored this cycle; 0 when gated.
    always_comb begin
        push_ok  = bus.enable && !frozen_q && !bus.clear;
        v_sum    = SUM_W'(v_cnt);
        room     = SUM_W'(LBR_SIZE) - SUM_W'(count_q);
        keep     = (bus.freeze_on_full && (v_sum > room)) ? room : v_sum;
        if (!push_ok) keep = '0;
        live_sum = SUM_W'(count_q) + keep;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_addr[c] = tos_q + IDX_W'(1) + wr_off[c];
            wr_en[c]   = push_ok && bus.rec_valid[c] && (SUM_W'(wr_off[c]) < keep);
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en[c]) begin
                mem_d[wr_addr[c]].from_addr = bus.rec_from[c*DATA_WIDTH +: DATA_WIDTH];
                mem_d[wr_addr[c]].to_addr   = bus.rec_to[c*DATA_WIDTH +: DATA_WIDTH];
                mem_d[wr_addr[c]].mispred   = bus.rec_mispred[c];
            end
        end
    end

    always_comb begin
        tos_d      = tos_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        frozen_d   = frozen_q;
        if (bus.clear) begin
            tos_d      = '1;
            count_d    = '0;
            overflow_d = 1'b0;
            frozen_d   = 1'b0;
        end else if (bus.enable && frozen_q) begin
            if (|bus.rec_valid) overflow_d = 1'b1;
        end else if (bus.enable) begin
            tos_d = tos_q + keep[IDX_W-1:0];
            if (live_sum > SUM_W'(LBR_SIZE)) begin
                count_d    = CNT_W'(LBR_SIZE);
                overflow_d = 1'b1;
            end else begin
                count_d = live_sum[CNT_W-1:0];
            end
            if (bus.freeze_on_full) begin
                if (v_sum > keep) begin
                    overflow_d = 1'b1;
                    frozen_d   = 1'b1;
                end
                if (live_sum == SUM_W'(LBR_SIZE)) frozen_d = 1'b1;
            end
        end
    end

    // Read path sees pre-edge tos/count/array: no bypass of a same-cycle push.
    always_comb begin
        rd_phys      = tos_q - bus.rd_idx;
        rd_hit_now   = CNT_W'(bus.rd_idx) < count_q;
        rd_ack_d     = bus.rd_req;
        rd_hit_d     = rd_hit_q;
        rd_from_d    = rd_from_q;
        rd_to_d      = rd_to_q;
        rd_mispred_d = rd_mispred_q;
        if (bus.rd_req) begin
            rd_hit_d     = rd_hit_now;
            rd_from_d    = rd_hit_now ? mem_q[rd_phys].from_addr : '0;
            rd_to_d      = rd_hit_now ? mem_q[rd_phys].to_addr   : '0;
            rd_mispred_d = rd_hit_now && mem_q[rd_phys].mispred;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tos_q        <= '1;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frozen_q     <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_hit_q     <= 1'b0;
            rd_from_q    <= '0;
            rd_to_q      <= '0;
            rd_mispred_q <= 1'b0;
        end else begin
            tos_q        <= tos_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            frozen_q     <= frozen_d;
            rd_ack_q     <= rd_ack_d;
            rd_hit_q     <= rd_hit_d;
            rd_from_q    <= rd_from_d;
            rd_to_q      <= rd_to_d;
            rd_mispred_q <= rd_mispred_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.tos        = tos_q;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.frozen     = frozen_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_hit     = rd_hit_q;
    assign bus.rd_from    = rd_from_q;
    assign bus.rd_to      = rd_to_q;
    assign bus.rd_mispred = rd_mispred_q;

endmodule
